uart_rx_sampler: RTL
====================

# uart_rx_sampler

Receive-side front end of the UART: synchronises the asynchronous serial line, recovers bit timing with a 16x oversampling baud tick, and majority-votes three mid-bit samples per bit. It emits one `data`/`valid_data` strobe per frame bit: start, 8 data bits, optional parity, 1–2 stop bits and 2 trailing idle bits. It sits directly upstream of the UART receive state machine and drives that block's `data` and `valid_data` inputs.

## Interface
- `OVERSAMPLE`, default 16: ticks per bit period. Must be ≥ 4.
- `WIDTH_BAUD_DIV`, default 16: width of the baud divisor.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `rx`, input, 1: raw serial line, asynchronous, idles high.
- `baud_div`, input, `WIDTH_BAUD_DIV`: clocks per oversample tick. 0 disables ticks.
- `paritybit`, input, 1: 1 means the frame carries a parity bit.
- `stopbit`, input, 1: 0 means 1 stop bit, 1 means 2 stop bits.
- `data`, output, 1: voted bit value, held until the next strobe.
- `valid_data`, output, 1: one-cycle strobe marking a new `data`.
- `busy`, output, 1: high from start-bit confirmation until the last bit of the frame is emitted.

## Operation
- **Synchroniser**
  - `rx` passes through 2 flip-flops, both reset to 1. All logic uses the synchronised `rxs`.
- **Tick generator**
  - Counter runs 0..`baud_div`-1. `tick` pulses for 1 cycle when the counter is at `baud_div`-1.
  - `baud_div` is re-read at each wrap.
  - `baud_div`=1 gives a tick every cycle; `baud_div`=0 holds the counter at 0 with no ticks.
- **Voting**
  - Phase counter `ph` runs 0..OVERSAMPLE-1 on ticks.
  - `rxs` is captured at `ph` = M-1, M and M+1, where M = OVERSAMPLE/2.
  - At the M+1 tick, bit = majority of the 3 captures.
- **States**
  - HUNT: on each tick with `rxs`=0, go to START with `ph` cleared to 1 (the detecting tick counts as phase 0).
  - START: at the M+1 vote:
    - vote 0: strobe `data`=0. Latch `paritybit`/`stopbit` into `nbits` = 8 + parity + (stopbit ? 2 : 1) + 2. Set `busy`, clear bit counter `bc`, go to BITS.
    - vote 1: false start; return to HUNT with no strobe.
  - BITS: at each M+1 vote, strobe the voted bit and increment `bc`. When `bc` reaches `nbits`-1 on a strobe, clear `busy` and go to HUNT. Bit values are passed through unchecked; framing checks belong downstream.
- Return to HUNT happens mid-way through the last idle bit. The next falling edge is detectable at once.
- `paritybit`/`stopbit` changes during a frame do not affect the current frame.
- Reset mid-frame: everything returns to reset values immediately, with no strobe. The frame in progress is lost.

## Timing
- **Reset values:** `data`=1, `valid_data`=0, `busy`=0. State HUNT; all counters 0; synchroniser 1/1.
- **Detection latency:** `rx` falling → `rxs` low is 2 cycles, then up to 1 tick period until the detecting tick.
- **Strobe timing:** `valid_data` and `data` are registered. They update in the cycle after the M+1 tick.
- **Strobe spacing:** exactly OVERSAMPLE·`baud_div` cycles between consecutive strobes of one frame. The start strobe comes (M+1)·`baud_div` cycles after the detecting tick.
- **`busy`:** rises with the start strobe and falls with the final strobe.
- **Strobes per frame:** 1 + `nbits`, i.e. 12 to 14.
- **Max baud:** 1 bit per 16 clocks (`baud_div`=1).

## Structure
- Shared UART parameter include holds:
  - `OVERSAMPLE` default
  - sampler state encodings HUNT=2'b00, START=2'b01, BITS=2'b10
  - frame constants: DATA_BITS=8, IDLE_BITS=2
- Sub-module `uart_baud_tick`: the divisor counter and `tick` output, reusable by the transmitter.
- Top level holds the synchroniser, phase counter, voter, FSM and bit counter.

## Test plan
- **Clean frame.** Setup: `baud_div`=4, `paritybit`=0, `stopbit`=0. Stimulus: send 0x5A LSB-first with 1 stop bit and idle. Expect 12 strobes: 0, 0,1,0,1,1,0,1,0, 1, 1, 1, spaced 64 cycles. `busy` high from strobe 1 to strobe 12.
- **False start.** Stimulus: 2-tick-wide (8-cycle) low glitch on `rx` at `baud_div`=4. Expect no `valid_data`, `busy` stays 0, state back in HUNT.
- **Noise rejection.** Stimulus: invert `rx` for exactly 1 tick at phase M of data bit 3 (value 1). Expect voted bit is still 1 and the strobe count is unchanged.
- **Frame length.** Stimulus: `paritybit`=1, `stopbit`=1. Expect 14 strobes. Toggling `paritybit` mid-frame leaves the count at 14.
- **Back-to-back frames.** Stimulus: second start bit begins right after the 2 idle bits. Expect the second frame is detected and 24 strobes total.
- **Reset mid-frame.** Stimulus: assert `rst` after strobe 5. Expect outputs 1/0/0 asynchronously. After release, a new frame is received correctly.

Source files
------------

// File: rtl/uart_rx_sampler_pkg.sv
// rtl/uart_rx_sampler_pkg.sv - shared UART receive constants, state codes and helpers
package uart_rx_sampler_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  localparam logic [1:0] ST_HUNT  = 2'b00;
  localparam logic [1:0] ST_START = 2'b01;
  localparam logic [1:0] ST_BITS  = 2'b10;

  localparam int DATA_BITS = 8;
  localparam int IDLE_BITS = 2;

  // Bits strobed after the start bit: data, optional parity, stop(s), trailing idle.
  function automatic logic [3:0] frame_nbits(input logic parity_en, input logic two_stop);
    logic [3:0] n;
    n = 4'(DATA_BITS) + 4'(IDLE_BITS);
    if (parity_en) n = n + 4'd1;
    n = n + (two_stop ? 4'd2 : 4'd1);
    return n;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler_baud_tick.sv
// rtl/uart_rx_sampler_baud_tick.sv - oversample tick generator (uart_baud_tick)
// Divisor is captured at each wrap so a mid-period change never shortens a tick period.
module uart_baud_tick #(
  parameter int WIDTH_BAUD_DIV = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH_BAUD_DIV-1:0] baud_div,
  output logic                      tick
);

  localparam logic [WIDTH_BAUD_DIV-1:0] ONE = WIDTH_BAUD_DIV'(1);

  logic [WIDTH_BAUD_DIV-1:0] cnt;
  logic [WIDTH_BAUD_DIV-1:0] div_q;

  assign tick = (div_q != '0) && (cnt == div_q - ONE);

  // A zero divisor keeps reloading, so a later non-zero value is picked up immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (div_q == '0 || tick) begin
      cnt   <= '0;
      div_q <= baud_div;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - UART receive front end: synchroniser, bit timing recovery, 3-sample voting
// Emits one data/valid_data strobe per frame bit, including stop and trailing idle bits.
module uart_rx_sampler
  import uart_rx_sampler_pkg::*;
#(
  parameter int OVERSAMPLE     = OVERSAMPLE_DEFAULT,
  parameter int WIDTH_BAUD_DIV = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  input  logic [WIDTH_BAUD_DIV-1:0] baud_div,
  input  logic                      paritybit,
  input  logic                      stopbit,
  output logic                      data,
  output logic                      valid_data,
  output logic                      busy
);

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam int MID  = OVERSAMPLE / 2;

  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_S0   = PH_W'(MID - 1);
  localparam logic [PH_W-1:0] PH_S1   = PH_W'(MID);
  localparam logic [PH_W-1:0] PH_VOTE = PH_W'(MID + 1);

  logic            tick;
  logic            rx_meta;
  logic            rxs;
  logic [1:0]      state;
  logic [PH_W-1:0] ph;
  logic            s_lo;
  logic            s_mid;
  logic [3:0]      bc;
  logic [3:0]      nbits;

  logic in_frame;
  logic at_vote;
  logic vote;
  logic hunt_detect;
  logic start_ok;
  logic false_start;
  logic bit_emit;
  logic last_bit;

  uart_baud_tick #(
    .WIDTH_BAUD_DIV(WIDTH_BAUD_DIV)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .baud_div (baud_div),
    .tick     (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // The third sample is the live line at the vote tick, not a stored capture.
  assign vote        = majority3(s_lo, s_mid, rxs);
  assign in_frame    = (state == ST_START) || (state == ST_BITS);
  assign at_vote     = tick && in_frame && (ph == PH_VOTE);
  assign hunt_detect = tick && (state == ST_HUNT) && !rxs;
  assign start_ok    = at_vote && (state == ST_START) && !vote;
  assign false_start = at_vote && (state == ST_START) && vote;
  assign bit_emit    = at_vote && (state == ST_BITS);
  assign last_bit    = bit_emit && (bc == nbits - 4'd1);

  // The detecting tick counts as phase 0, so the frame starts at phase 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= '0;
    end else if (hunt_detect) begin
      ph <= PH_ONE;
    end else if (false_start || last_bit) begin
      ph <= '0;
    end else if (tick && in_frame) begin
      ph <= (ph == PH_LAST) ? '0 : ph + PH_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_lo  <= 1'b0;
      s_mid <= 1'b0;
    end else if (tick && in_frame) begin
      if (ph == PH_S0) s_lo  <= rxs;
      if (ph == PH_S1) s_mid <= rxs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_HUNT;
    end else if (hunt_detect) begin
      state <= ST_START;
    end else if (start_ok) begin
      state <= ST_BITS;
    end else if (false_start || last_bit) begin
      state <= ST_HUNT;
    end else if (!in_frame && state != ST_HUNT) begin
      state <= ST_HUNT;
    end
  end

  // Frame shape is frozen at start confirmation; later config changes wait for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bc    <= '0;
      nbits <= '0;
    end else if (start_ok) begin
      bc    <= '0;
      nbits <= frame_nbits(paritybit, stopbit);
    end else if (last_bit) begin
      bc <= '0;
    end else if (bit_emit) begin
      bc <= bc + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= 1'b1;
      valid_data <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid_data <= start_ok || bit_emit;
      if (start_ok) begin
        data <= 1'b0;
        busy <= 1'b1;
      end else if (bit_emit) begin
        data <= vote;
        if (last_bit) busy <= 1'b0;
      end
    end
  end

endmodule
